cpu_cycle_sequencer: RTL and testbench

// - Timing/prefix sequencer that drives the opcode microcode decoders (main and CB-prefixed).
// - Generates one-hot T-state (step) and M-cycle (count) vectors, latches fetched opcodes and owns the CB-prefix state.
// - Consumes the decoders' fetch/disable strobes, closing the loop between instruction fetch and microcode.

---
 rtl/cpu_cycle_sequencer_if.sv | 44 ++++
 rtl/cpu_cycle_sequencer.sv | 167 ++++++++++++++++
 tb/tb_cpu_cycle_sequencer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_cycle_sequencer_if.sv
// Bus bundle between the cycle sequencer, the opcode decoders and the data bus.
// HALT_SUPPORT_EN adds the i_Halt/i_Wake/o_Halted signals.
interface cpu_cycle_sequencer_if #(
  parameter int COUNT_W = 8
);
  logic               i_Stall;
  logic               i_IR_Fetch;
  logic               i_Disable_CB;
  logic [7:0]         i_Data;
  logic [3:0]         o_Cycle_Step;
  logic [COUNT_W-1:0] o_Cycle_Count;
  logic [7:0]         o_IR;
  logic [7:0]         o_Z;
  logic               o_CB_Active;
  logic               o_Prefix_Fetch;
  logic               o_Overflow;
`ifdef HALT_SUPPORT_EN
  logic               i_Halt;
  logic               i_Wake;
  logic               o_Halted;
`endif

  // Sequencer side: produces the timing vectors and latched opcodes.
  modport master (
    input  i_Stall, i_IR_Fetch, i_Disable_CB, i_Data,
`ifdef HALT_SUPPORT_EN
    input  i_Halt, i_Wake,
    output o_Halted,
`endif
    output o_Cycle_Step, o_Cycle_Count, o_IR, o_Z,
    output o_CB_Active, o_Prefix_Fetch, o_Overflow
  );

  // Decoder / bus side: supplies strobes and data, consumes timing.
  modport slave (
    output i_Stall, i_IR_Fetch, i_Disable_CB, i_Data,
`ifdef HALT_SUPPORT_EN
    output i_Halt, i_Wake,
    input  o_Halted,
`endif
    input  o_Cycle_Step, o_Cycle_Count, o_IR, o_Z,
    input  o_CB_Active, o_Prefix_Fetch, o_Overflow
  );
endinterface

// File: rtl/cpu_cycle_sequencer.sv
// T-state / M-cycle sequencer with opcode latches and CB-prefix state machine.
// Optional HALT state is enabled by defining HALT_SUPPORT_EN.
module cpu_cycle_sequencer #(
  parameter int         COUNT_W  = 8,
  parameter logic [7:0] RESET_IR = 8'h00
) (
  input logic                   i_Clk,
  input logic                   i_Reset,
  cpu_cycle_sequencer_if.master bus
);

  localparam logic [7:0] CB_PREFIX = 8'hCB;

  typedef enum logic [1:0] {
    ST_NORMAL,
    ST_PREFIX,
    ST_CB
`ifdef HALT_SUPPORT_EN
    , ST_HALT
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         step_q, step_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [7:0]         ir_q, ir_d;
  logic [7:0]         z_q, z_d;
  logic               cb_active_q, cb_active_d;
  logic               prefix_fetch_q, prefix_fetch_d;
  logic               overflow_q, overflow_d;
  logic               boundary;
  logic               fetch_now;
  logic               halt_req;
`ifdef HALT_SUPPORT_EN
  logic               halted_q, halted_d;
  assign halt_req = bus.i_Halt;
`else
  assign halt_req = 1'b0;
`endif

  assign boundary = !bus.i_Stall && step_q[3];

  // A stray fetch strobe inside CB without the done strobe still ends the instruction.
  always_comb begin
    case (state_q)
      ST_PREFIX: fetch_now = prefix_fetch_q;
      ST_CB:     fetch_now = bus.i_IR_Fetch || bus.i_Disable_CB;
`ifdef HALT_SUPPORT_EN
      ST_HALT:   fetch_now = 1'b1;
`endif
      default:   fetch_now = bus.i_IR_Fetch;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    step_d         = step_q;
    count_d        = count_q;
    ir_d           = ir_q;
    z_d            = z_q;
    cb_active_d    = cb_active_q;
    prefix_fetch_d = prefix_fetch_q;
    overflow_d     = overflow_q;
`ifdef HALT_SUPPORT_EN
    halted_d       = halted_q;
`endif

    if (!bus.i_Stall) begin
      step_d = {step_q[2:0], step_q[3]};
    end

    if (boundary) begin
      if (fetch_now) begin
        count_d = COUNT_W'(1);
      end else if (count_q[COUNT_W-1]) begin
        overflow_d = 1'b1;
      end else begin
        count_d = count_q << 1;
      end

      case (state_q)
        ST_NORMAL: begin
          if (bus.i_IR_Fetch && !halt_req) begin
            ir_d = bus.i_Data;
            if (bus.i_Data == CB_PREFIX) begin
              state_d        = ST_PREFIX;
              prefix_fetch_d = 1'b1;
            end
          end
`ifdef HALT_SUPPORT_EN
          if (bus.i_IR_Fetch && halt_req) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end
`endif
        end
        ST_PREFIX: begin
          z_d            = bus.i_Data;
          state_d        = ST_CB;
          prefix_fetch_d = 1'b0;
          cb_active_d    = 1'b1;
        end
        ST_CB: begin
          if (fetch_now) begin
            cb_active_d = 1'b0;
            ir_d        = bus.i_Data;
            if (bus.i_Data == CB_PREFIX) begin
              state_d        = ST_PREFIX;
              prefix_fetch_d = 1'b1;
            end else begin
              state_d = ST_NORMAL;
            end
          end
        end
`ifdef HALT_SUPPORT_EN
        ST_HALT: begin
          if (bus.i_Wake) begin
            state_d  = ST_NORMAL;
            halted_d = 1'b0;
          end
        end
`endif
        default: state_d = ST_NORMAL;
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q        <= ST_NORMAL;
      step_q         <= 4'b0001;
      count_q        <= COUNT_W'(1);
      ir_q           <= RESET_IR;
      z_q            <= 8'h00;
      cb_active_q    <= 1'b0;
      prefix_fetch_q <= 1'b0;
      overflow_q     <= 1'b0;
`ifdef HALT_SUPPORT_EN
      halted_q       <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      step_q         <= step_d;
      count_q        <= count_d;
      ir_q           <= ir_d;
      z_q            <= z_d;
      cb_active_q    <= cb_active_d;
      prefix_fetch_q <= prefix_fetch_d;
      overflow_q     <= overflow_d;
`ifdef HALT_SUPPORT_EN
      halted_q       <= halted_d;
`endif
    end
  end

  assign bus.o_Cycle_Step   = step_q;
  assign bus.o_Cycle_Count  = count_q;
  assign bus.o_IR           = ir_q;
  assign bus.o_Z            = z_q;
  assign bus.o_CB_Active    = cb_active_q;
  assign bus.o_Prefix_Fetch = prefix_fetch_q;
  assign bus.o_Overflow     = overflow_q;
`ifdef HALT_SUPPORT_EN
  assign bus.o_Halted       = halted_q;
`endif

endmodule

// File: tb/tb_cpu_cycle_sequencer.sv
// Self-checking bench for cpu_cycle_sequencer: directed vectors, an abstract
// phase/M-cycle/mode model compared every cycle, and literal pin-point checks.
module tb_cpu_cycle_sequencer;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cpu_cycle_sequencer_if #(.COUNT_W(8)) bus_if ();

  cpu_cycle_sequencer #(.COUNT_W(8), .RESET_IR(8'h00)) dut (
    .i_Clk   (clk),
    .i_Reset (rst),
    .bus     (bus_if)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model: T-state phase 0..3, M-cycle index, mode 0=normal 1=prefix 2=cb.
  int         m_phase;
  int         m_mc;
  int         m_mode;
  logic [7:0] m_ir;
  logic [7:0] m_z;
  bit         m_ovf;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_advance();
    if (m_mc == 7) m_ovf = 1'b1;
    else m_mc++;
  endtask

  task automatic model_update(input bit r, input bit stall, input bit fetch,
                              input bit dis, input logic [7:0] data);
    if (r) begin
      m_phase = 0; m_mc = 0; m_mode = 0; m_ir = 8'h00; m_z = 8'h00; m_ovf = 1'b0;
    end else if (!stall) begin
      if (m_phase == 3) begin
        case (m_mode)
          0: begin
            if (fetch) begin
              m_mc = 0;
              m_ir = data;
              if (data == 8'hCB) m_mode = 1;
            end else model_advance();
          end
          1: begin
            m_z = data; m_mode = 2; m_mc = 0;
          end
          default: begin
            if (fetch || dis) begin
              m_mc = 0;
              m_ir = data;
              m_mode = (data == 8'hCB) ? 1 : 0;
            end else model_advance();
          end
        endcase
      end
      m_phase = (m_phase + 1) % 4;
    end
  endtask

  task automatic applyStimulus(input bit r, input bit stall, input bit fetch,
                               input bit dis, input logic [7:0] data);
    rst                 = r;
    bus_if.i_Stall      = stall;
    bus_if.i_IR_Fetch   = fetch;
    bus_if.i_Disable_CB = dis;
    bus_if.i_Data       = data;
    @(posedge clk);
    model_update(r, stall, fetch, dis, data);
    #1;
  endtask

  // One full unstalled M-cycle; strobes and data only matter on the boundary clock.
  task automatic mcycle(input bit fetch, input bit dis, input logic [7:0] data);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'hA5);
    applyStimulus(1'b0, 1'b0, fetch, dis, data);
  endtask

  task automatic checkOutput();
    logic [3:0] exp_step;
    logic [7:0] exp_count;
    exp_step  = 4'b0001 << m_phase;
    exp_count = 8'b0000_0001 << m_mc;
    cmp("step",         32'(bus_if.o_Cycle_Step),   32'(exp_step));
    cmp("count",        32'(bus_if.o_Cycle_Count),  32'(exp_count));
    cmp("ir",           32'(bus_if.o_IR),           32'(m_ir));
    cmp("z",            32'(bus_if.o_Z),            32'(m_z));
    cmp("cb_active",    32'(bus_if.o_CB_Active),    32'(m_mode == 2));
    cmp("prefix_fetch", 32'(bus_if.o_Prefix_Fetch), 32'(m_mode == 1));
    cmp("overflow",     32'(bus_if.o_Overflow),     32'(m_ovf));
  endtask

  always @(negedge clk) begin
    if (cmp_en) checkOutput();
  end

  initial begin
`ifdef HALT_SUPPORT_EN
    bus_if.i_Halt = 1'b0;
    bus_if.i_Wake = 1'b0;
`endif
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    cmp_en = 1'b1;
    cmp("rst_step",  32'(bus_if.o_Cycle_Step),  32'h1);
    cmp("rst_count", 32'(bus_if.o_Cycle_Count), 32'h1);
    cmp("rst_ir",    32'(bus_if.o_IR),          32'h00);
    cmp("rst_ovf",   32'(bus_if.o_Overflow),    32'h0);

    mcycle(1'b1, 1'b0, 8'h3E);
    cmp("fetch_ir",    32'(bus_if.o_IR),          32'h3E);
    cmp("fetch_count", 32'(bus_if.o_Cycle_Count), 32'h01);
    cmp("fetch_step",  32'(bus_if.o_Cycle_Step),  32'h1);
    for (int i = 0; i < 3; i++) mcycle(1'b0, 1'b0, 8'h00);
    cmp("three_mc_count", 32'(bus_if.o_Cycle_Count), 32'h08);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'hFF);
    cmp("stall_step",  32'(bus_if.o_Cycle_Step),  32'h4);
    cmp("stall_count", 32'(bus_if.o_Cycle_Count), 32'h08);
    cmp("stall_ir",    32'(bus_if.o_IR),          32'h3E);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    cmp("resume_step", 32'(bus_if.o_Cycle_Step), 32'h8);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h77);
    cmp("stall_bnd_ir", 32'(bus_if.o_IR), 32'h3E);

    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'hCB);
    cmp("cb_ir", 32'(bus_if.o_IR), 32'hCB);
    for (int i = 0; i < 3; i++) begin
      cmp("prefix_hold", 32'(bus_if.o_Prefix_Fetch), 32'h1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'hA5);
    end
    cmp("prefix_hold", 32'(bus_if.o_Prefix_Fetch), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h46);
    cmp("prefix_z",  32'(bus_if.o_Z),            32'h46);
    cmp("prefix_cb", 32'(bus_if.o_CB_Active),    32'h1);
    cmp("prefix_pf", 32'(bus_if.o_Prefix_Fetch), 32'h0);

    mcycle(1'b0, 1'b0, 8'h00);
    mcycle(1'b1, 1'b1, 8'hCB);
    cmp("b2b_cb_off", 32'(bus_if.o_CB_Active),    32'h0);
    cmp("b2b_pf_on",  32'(bus_if.o_Prefix_Fetch), 32'h1);
    mcycle(1'b0, 1'b0, 8'h11);
    cmp("b2b_z",  32'(bus_if.o_Z),         32'h11);
    cmp("b2b_cb", 32'(bus_if.o_CB_Active), 32'h1);

    mcycle(1'b1, 1'b0, 8'h3E);
    cmp("proto_ir", 32'(bus_if.o_IR),        32'h3E);
    cmp("proto_cb", 32'(bus_if.o_CB_Active), 32'h0);
    mcycle(1'b0, 1'b1, 8'h55);
    cmp("dis_ignored_count", 32'(bus_if.o_Cycle_Count), 32'h02);

    mcycle(1'b1, 1'b0, 8'hCB);
    mcycle(1'b0, 1'b0, 8'h46);
    mcycle(1'b0, 1'b0, 8'h00);
    mcycle(1'b0, 1'b0, 8'h00);
    cmp("midcb_count", 32'(bus_if.o_Cycle_Count), 32'h04);
    cmp("midcb_cb",    32'(bus_if.o_CB_Active),   32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    cmp("midrst_step",  32'(bus_if.o_Cycle_Step),  32'h1);
    cmp("midrst_count", 32'(bus_if.o_Cycle_Count), 32'h1);
    cmp("midrst_cb",    32'(bus_if.o_CB_Active),   32'h0);
    cmp("midrst_ir",    32'(bus_if.o_IR),          32'h00);

    for (int i = 0; i < 7; i++) mcycle(1'b0, 1'b0, 8'h00);
    cmp("msb_count", 32'(bus_if.o_Cycle_Count), 32'h80);
    cmp("msb_ovf",   32'(bus_if.o_Overflow),    32'h0);
    mcycle(1'b0, 1'b0, 8'h00);
    cmp("ovf_count", 32'(bus_if.o_Cycle_Count), 32'h80);
    cmp("ovf_set",   32'(bus_if.o_Overflow),    32'h1);
    mcycle(1'b0, 1'b0, 8'h00);
    mcycle(1'b1, 1'b0, 8'h00);
    cmp("ovf_sticky",       32'(bus_if.o_Overflow),    32'h1);
    cmp("ovf_fetch_count",  32'(bus_if.o_Cycle_Count), 32'h01);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    cmp("ovf_cleared", 32'(bus_if.o_Overflow), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
